// File: rtl/vga_config_regs_pkg.sv
// Shared definitions for the VGA configuration register file: register map,
// command opcode fields, reset constants, sequencer states and STATUS layout.
package vga_cfg_pkg;

   localparam logic [1:0] REG_CONFIG  = 2'd0;
   localparam logic [1:0] REG_SCRATCH = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_ID      = 2'd3;

   localparam logic [7:0] OP_W   = 8'h80;
   localparam logic [7:0] OP_C   = 8'h40;
   localparam logic [7:0] OP_IDX = 8'h03;

   localparam logic [31:0] CONFIG_RESET = 32'h80FC_0000;
   localparam logic [31:0] ID_VALUE     = 32'h5647_4131;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_RDATA = 2'd2,
      ST_DRAIN = 2'd3
   } seq_state_t;

   localparam int STAT_PENDING   = 0;
   localparam int STAT_BUSY      = 1;
   localparam int STAT_ERR_LSB   = 8;
   localparam int STAT_FRAME_LSB = 16;

   function automatic logic [31:0] pack_status(input logic [15:0] frames,
                                               input logic [7:0]  errs,
                                               input logic        busy,
                                               input logic        pending);
      logic [31:0] s;
      s                                 = '0;
      s[STAT_FRAME_LSB +: 16]           = frames;
      s[STAT_ERR_LSB +: 8]              = errs;
      s[STAT_BUSY]                      = busy;
      s[STAT_PENDING]                   = pending;
      return s;
   endfunction

endpackage

// File: rtl/vga_config_regs_if.sv
// Byte-level link to the SPI peripheral: chip select, received bytes, and the
// byte to shift out on MISO.
interface vga_config_regs_if;
   logic       ss;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic [7:0] tx_byte;

   modport master (output ss, output rx_valid, output rx_byte, input tx_byte);
   modport slave  (input ss, input rx_valid, input rx_byte, output tx_byte);
endinterface

// File: rtl/vga_config_regs_seq.sv
// Command sequencer: decodes command bytes, assembles write data MSB first and
// paces readback; emits one-cycle strobes that the register file acts on.
module cfg_cmd_sequencer
   import vga_cfg_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ss,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        busy,
   output logic        wr_en,
   output logic [1:0]  wr_idx,
   output logic [31:0] wr_data,
   output logic [1:0]  rd_idx,
   output logic        rd_load,
   output logic        rd_shift,
   output logic        tx_clear,
   output logic        commit_req,
   output logic        err_inc
);

   seq_state_t  state, state_next;
   logic [1:0]  cnt, cnt_next;
   logic [23:0] asm_q, asm_next;
   logic [1:0]  idx_q, idx_next;
   logic        is_write, is_read, is_commit;

   assign is_write  = ((rx_byte & ~OP_IDX) == OP_W) && !rx_byte[1];
   assign is_read   = ((rx_byte & ~OP_IDX) == 8'h00);
   assign is_commit = (rx_byte == OP_C);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         asm_q <= '0;
         idx_q <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         asm_q <= asm_next;
         idx_q <= idx_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      asm_next   = asm_q;
      idx_next   = idx_q;
      wr_en      = 1'b0;
      wr_idx     = idx_q;
      wr_data    = {asm_q, rx_byte};
      rd_idx     = rx_byte[1:0];
      rd_load    = 1'b0;
      rd_shift   = 1'b0;
      tx_clear   = 1'b0;
      commit_req = 1'b0;
      err_inc    = 1'b0;
      busy       = (state != ST_IDLE);

      // Chip select high aborts whatever is in flight, even a coincident byte
      if (ss) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
         asm_next   = '0;
         tx_clear   = 1'b1;
      end else if (rx_valid) begin
         case (state)
            ST_IDLE: begin
               cnt_next = '0;
               if (is_write) begin
                  idx_next   = rx_byte[1:0];
                  state_next = ST_WDATA;
               end else if (is_read) begin
                  rd_load    = 1'b1;
                  state_next = ST_RDATA;
               end else if (is_commit) begin
                  commit_req = 1'b1;
                  state_next = ST_DRAIN;
               end else begin
                  err_inc    = 1'b1;
                  state_next = ST_DRAIN;
               end
            end
            ST_WDATA: begin
               if (cnt == 2'd3) begin
                  wr_en      = 1'b1;
                  cnt_next   = '0;
                  state_next = ST_DRAIN;
               end else begin
                  asm_next = {asm_q[15:0], rx_byte};
                  cnt_next = cnt + 2'd1;
               end
            end
            ST_RDATA: begin
               if (cnt == 2'd3) begin
                  tx_clear   = 1'b1;
                  cnt_next   = '0;
                  state_next = ST_DRAIN;
               end else begin
                  rd_shift = 1'b1;
                  cnt_next = cnt + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/vga_config_regs.sv
// Register file between the SPI byte receiver and the pixel path; CONFIG is
// double-buffered and the active copy only changes at frame start or on commit.
module vga_config_regs
   import vga_cfg_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   vga_config_regs_if.slave         spi,
   input  logic                     frame_start,
   output logic [31:0]              config_data,
   output logic                     cfg_pending
);

   logic        busy, wr_en, rd_load, rd_shift, tx_clear, commit_req, err_inc;
   logic [1:0]  wr_idx, rd_idx;
   logic [31:0] wr_data, rd_val;
   logic [31:0] active_q, shadow_q, scratch_q;
   logic [15:0] frame_count;
   logic [7:0]  err_count, tx_q;
   logic [23:0] rd_buf;
   logic        pending_q, commit;

   cfg_cmd_sequencer u_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .ss         (spi.ss),
      .rx_valid   (spi.rx_valid),
      .rx_byte    (spi.rx_byte),
      .busy       (busy),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .rd_idx     (rd_idx),
      .rd_load    (rd_load),
      .rd_shift   (rd_shift),
      .tx_clear   (tx_clear),
      .commit_req (commit_req),
      .err_inc    (err_inc)
   );

   always_comb begin
      rd_val = '0;
      case (rd_idx)
         REG_CONFIG:  rd_val = shadow_q;
         REG_SCRATCH: rd_val = scratch_q;
         REG_STATUS:  rd_val = pack_status(frame_count, err_count, busy, pending_q);
         REG_ID:      rd_val = ID_VALUE;
         default:     rd_val = '0;
      endcase
   end

   assign commit = commit_req || (frame_start && pending_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_q    <= CONFIG_RESET;
         shadow_q    <= CONFIG_RESET;
         scratch_q   <= '0;
         pending_q   <= 1'b0;
         frame_count <= '0;
         err_count   <= '0;
         tx_q        <= '0;
         rd_buf      <= '0;
      end else begin
         // A CONFIG write landing with a commit still leaves the new value pending
         if (commit) begin
            active_q  <= shadow_q;
            pending_q <= 1'b0;
         end
         if (wr_en && wr_idx == REG_CONFIG) begin
            shadow_q  <= wr_data;
            pending_q <= 1'b1;
         end
         if (wr_en && wr_idx == REG_SCRATCH)
            scratch_q <= wr_data;
         if (frame_start)
            frame_count <= frame_count + 16'd1;
         if (err_inc && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
         if (tx_clear) begin
            tx_q <= '0;
         end else if (rd_load) begin
            tx_q   <= rd_val[31:24];
            rd_buf <= rd_val[23:0];
         end else if (rd_shift) begin
            tx_q   <= rd_buf[23:16];
            rd_buf <= {rd_buf[15:0], 8'h00};
         end
      end
   end

   assign config_data = active_q;
   assign cfg_pending = pending_q;
   assign spi.tx_byte = tx_q;

endmodule

// File: tb/tb_vga_config_regs.sv
// Randomized bench for vga_config_regs against a transaction-level model of
// the register map, frame commits and readback byte order.
module tb_vga_config_regs;
   import vga_cfg_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic [31:0] config_data;
   logic        cfg_pending;

   vga_config_regs_if spi();

   vga_config_regs dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi         (spi.slave),
      .frame_start (frame_start),
      .config_data (config_data),
      .cfg_pending (cfg_pending)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_active, m_shadow, m_scratch;
   logic [15:0] m_frames;
   logic [7:0]  m_err;
   logic        m_pending;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_reg(input logic [1:0] idx);
      case (idx)
         2'd0:    return m_shadow;
         2'd1:    return m_scratch;
         2'd2:    return {m_frames, m_err, 8'h00} | {31'd0, m_pending};
         default: return 32'h5647_4131;
      endcase
   endfunction

   function automatic bit is_legal(input logic [7:0] b);
      return (b <= 8'h03) || (b == 8'h80) || (b == 8'h81) || (b == 8'h40);
   endfunction

   task automatic model_frame();
      m_frames = m_frames + 16'd1;
      if (m_pending) begin
         m_active  = m_shadow;
         m_pending = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit fs = 1'b0);
      repeat (7) @(negedge clk);
      spi.rx_byte  = b;
      spi.rx_valid = 1'b1;
      frame_start  = fs;
      @(negedge clk);
      spi.rx_valid = 1'b0;
      frame_start  = 1'b0;
   endtask

   task automatic end_txn();
      @(negedge clk);
      spi.ss = 1'b1;
      @(negedge clk);
      chk("tx_after_ss", {24'd0, spi.tx_byte}, 32'h0);
      spi.ss = 1'b0;
   endtask

   task automatic drain_noise();
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) send_byte(8'($urandom));
   endtask

   task automatic frame();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      model_frame();
      chk("frame_cfg", config_data, m_active);
      chk("frame_pend", {31'd0, cfg_pending}, {31'd0, m_pending});
   endtask

   task automatic do_write(input logic [1:0] idx, input logic [31:0] v, input bit fs_last = 1'b0);
      send_byte(8'h80 | {6'd0, idx});
      send_byte(v[31:24]);
      send_byte(v[23:16]);
      send_byte(v[15:8]);
      send_byte(v[7:0], fs_last);
      if (fs_last) model_frame();
      if (idx == 2'd0) begin
         m_shadow  = v;
         m_pending = 1'b1;
      end else begin
         m_scratch = v;
      end
      chk("wr_pend", {31'd0, cfg_pending}, {31'd0, m_pending});
      chk("wr_cfg", config_data, m_active);
      drain_noise();
      end_txn();
   endtask

   task automatic do_read(input logic [1:0] idx);
      logic [31:0] e;
      e = model_reg(idx);
      send_byte({6'd0, idx});
      chk($sformatf("rd%0d_b0", idx), {24'd0, spi.tx_byte}, {24'd0, e[31:24]});
      for (int k = 1; k < 4; k++) begin
         send_byte(8'($urandom));
         chk($sformatf("rd%0d_b%0d", idx, k), {24'd0, spi.tx_byte}, {24'd0, e[31-8*k -: 8]});
      end
      send_byte(8'($urandom));
      chk($sformatf("rd%0d_end", idx), {24'd0, spi.tx_byte}, 32'h0);
      drain_noise();
      end_txn();
   endtask

   task automatic do_commit(input bit fs = 1'b0);
      send_byte(8'h40, fs);
      if (fs) m_frames = m_frames + 16'd1;
      m_active  = m_shadow;
      m_pending = 1'b0;
      chk("commit_cfg", config_data, m_active);
      chk("commit_pend", {31'd0, cfg_pending}, 32'h0);
      drain_noise();
      end_txn();
   endtask

   task automatic do_illegal(input logic [7:0] b);
      send_byte(b);
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      chk("ill_cfg", config_data, m_active);
      drain_noise();
      end_txn();
   endtask

   function automatic logic [7:0] rand_illegal();
      logic [7:0] b;
      b = 8'($urandom);
      while (is_legal(b)) b = 8'($urandom);
      return b;
   endfunction

   initial begin
      spi.ss       = 1'b1;
      spi.rx_valid = 1'b0;
      spi.rx_byte  = 8'h00;
      m_active  = 32'h80FC_0000;
      m_shadow  = 32'h80FC_0000;
      m_scratch = 32'h0;
      m_frames  = 16'h0;
      m_err     = 8'h0;
      m_pending = 1'b0;

      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cfg", config_data, 32'h80FC_0000);
      chk("rst_pend", {31'd0, cfg_pending}, 32'h0);
      chk("rst_tx", {24'd0, spi.tx_byte}, 32'h0);
      spi.ss = 1'b0;

      frame();
      frame();
      do_read(2'd2);
      do_read(2'd0);

      do_write(2'd0, 32'h1234_5678);
      frame();

      do_read(2'd3);
      do_write(2'd1, 32'hDEAD_BEEF);
      do_read(2'd1);

      send_byte(8'h80);
      send_byte(8'hAA);
      send_byte(8'hBB);
      end_txn();
      do_read(2'd0);
      chk("abort_pend", {31'd0, cfg_pending}, {31'd0, m_pending});

      do_illegal(8'h82);
      do_illegal(8'h07);
      do_illegal(8'hFF);
      do_read(2'd2);

      do_write(2'd0, 32'hCAFE_0001);
      do_write(2'd0, 32'h0BAD_F00D, 1'b1);
      do_read(2'd2);
      frame();
      do_write(2'd0, 32'h7777_1111);
      do_commit();
      do_write(2'd0, 32'h2468_ACE0);
      do_commit(1'b1);
      frame();

      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 6))
            0: do_write(2'($urandom_range(0, 1)), $urandom);
            1: do_read(2'($urandom_range(0, 3)));
            2: do_illegal(rand_illegal());
            3: do_commit(1'($urandom_range(0, 1)));
            4: frame();
            5: do_write(2'd0, $urandom, 1'b1);
            default: begin
               send_byte(8'h80 | 8'($urandom_range(0, 1)));
               for (int k = 0; k < $urandom_range(0, 3); k++) send_byte(8'($urandom));
               end_txn();
            end
         endcase
      end
      do_read(2'd0);
      do_read(2'd1);
      do_read(2'd2);

      for (int i = 0; i < 300; i++) do_illegal(rand_illegal());
      do_read(2'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
